// File: rtl/stream_issue_ctrl_pkg.sv
// Shared types and defaults for the stream issue controller.
// Holds the FSM state encoding, the default ROM geometry and the
// next-state helper used by the top-level controller.
package stream_issue_ctrl_pkg;

  localparam int unsigned ROM_WIDTH_DEF     = 40;
  localparam int unsigned ROM_ADDR_BITS_DEF = 8;
  localparam int unsigned STATE_W           = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  // Next state: warm-up completion enters RUN, prog_full toggles RUN/STALL,
  // and the unused encoding falls back to WARMUP.
  function automatic state_t fsm_next(state_t cur, logic warm_done, logic prog_full);
    state_t nxt;
    nxt = cur;
    case (cur)
      ST_WARMUP: if (warm_done)  nxt = ST_RUN;
      ST_RUN:    if (prog_full)  nxt = ST_STALL;
      ST_STALL:  if (!prog_full) nxt = ST_RUN;
      default:                   nxt = ST_WARMUP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/stream_issue_ctrl_pc.sv
// Schedule program counter and instruction register.
// Ports:
//   bus_clk              clock
//   user_w_write_32_open synchronous active-low reset
//   imem_data            schedule memory read data (1-cycle synchronous read)
//   imem_addr            schedule memory address, wraps after LAST_ADDR
//   instruction          registered copy of imem_data, aligned to the data stream
module stream_issue_ctrl_pc
  import stream_issue_ctrl_pkg::*;
#(
  parameter int unsigned ROM_WIDTH     = ROM_WIDTH_DEF,
  parameter int unsigned ROM_ADDR_BITS = ROM_ADDR_BITS_DEF,
  parameter int unsigned LAST_ADDR     = 255
) (
  input  logic                     bus_clk,
  input  logic                     user_w_write_32_open,
  input  logic [ROM_WIDTH-1:0]     imem_data,
  output logic [ROM_ADDR_BITS-1:0] imem_addr,
  output logic [ROM_WIDTH-1:0]     instruction
);

  localparam logic [ROM_ADDR_BITS-1:0] ADDR_LAST = ROM_ADDR_BITS'(LAST_ADDR);

  // PC free-runs in every state; instruction lags the address by two cycles.
  always_ff @(posedge bus_clk) begin
    if (!user_w_write_32_open) begin
      imem_addr   <= '0;
      instruction <= '0;
    end else begin
      imem_addr   <= (imem_addr == ADDR_LAST) ? '0 : imem_addr + ROM_ADDR_BITS'(1);
      instruction <= imem_data;
    end
  end

endmodule

// File: rtl/stream_issue_ctrl.sv
// Issue controller in front of the CPU pipeline chain.
// Gates host writes until warm-up completes, paces input-FIFO reads to one
// per PERIOD cycles, raises data-valid for cpu_1 and drives the schedule PC.
// Ports:
//   bus_clk              clock
//   user_w_write_32_open synchronous active-low reset (channel-open flag)
//   wr_en_in / wr_en_out host write enable in, gated enable out (combinational)
//   in_fifo_empty        input FIFO empty
//   in_fifo_rd_en        input FIFO read pulse (registered)
//   din_v                data-valid to cpu_1, read pulse delayed one cycle
//   out_fifo_prog_full   back-pressure from the output FIFO
//   imem_addr/imem_data  schedule memory address / read data
//   instruction          instruction to cpu_1 (registered)
//   issue_count          read pulses issued, wrapping
//   state                current FSM state
module stream_issue_ctrl
  import stream_issue_ctrl_pkg::*;
#(
  parameter int unsigned ROM_WIDTH     = ROM_WIDTH_DEF,
  parameter int unsigned ROM_ADDR_BITS = ROM_ADDR_BITS_DEF,
  parameter int unsigned LAST_ADDR     = 255,
  parameter int unsigned WARMUP_CYCLES = 20,
  parameter int unsigned PERIOD        = 6
) (
  input  logic                     bus_clk,
  input  logic                     user_w_write_32_open,
  input  logic                     wr_en_in,
  output logic                     wr_en_out,
  input  logic                     in_fifo_empty,
  output logic                     in_fifo_rd_en,
  output logic                     din_v,
  input  logic                     out_fifo_prog_full,
  output logic [ROM_ADDR_BITS-1:0] imem_addr,
  input  logic [ROM_WIDTH-1:0]     imem_data,
  output logic [ROM_WIDTH-1:0]     instruction,
  output logic [31:0]              issue_count,
  output logic [1:0]               state
);

  localparam int unsigned CNT_W  = $clog2(WARMUP_CYCLES + 1);
  localparam int unsigned SLOT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0]  WARM_MAX  = CNT_W'(WARMUP_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PERIOD - 1);

  logic [CNT_W-1:0]  cycle_cnt;
  logic [SLOT_W-1:0] slot;
  state_t            state_q;
  logic              warm_done;
  logic              issue_ok;

  // True on the edge where cycle_cnt reaches (or already holds) WARMUP_CYCLES.
  assign warm_done = (cycle_cnt >= WARM_MAX - CNT_W'(1));

  // Back-pressure sampled at the same edge also blocks the pulse.
  assign issue_ok = (slot == '0) && (state_q == ST_RUN) &&
                    !in_fifo_empty && !out_fifo_prog_full;

  assign wr_en_out = wr_en_in & (cycle_cnt == WARM_MAX);
  assign state     = state_q;

  // FSM, saturating warm-up counter and read pacing.
  always_ff @(posedge bus_clk) begin
    if (!user_w_write_32_open) begin
      state_q       <= ST_WARMUP;
      cycle_cnt     <= '0;
      slot          <= '0;
      in_fifo_rd_en <= 1'b0;
      din_v         <= 1'b0;
      issue_count   <= '0;
    end else begin
      if (cycle_cnt != WARM_MAX) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      state_q       <= fsm_next(state_q, warm_done, out_fifo_prog_full);
      din_v         <= in_fifo_rd_en;
      in_fifo_rd_en <= issue_ok;
      // An issued slot always runs to completion, even through STALL.
      if (issue_ok) begin
        slot        <= SLOT_W'(1);
        issue_count <= issue_count + 32'd1;
      end else if (slot != '0) begin
        slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
      end
    end
  end

  stream_issue_ctrl_pc #(
    .ROM_WIDTH     (ROM_WIDTH),
    .ROM_ADDR_BITS (ROM_ADDR_BITS),
    .LAST_ADDR     (LAST_ADDR)
  ) u_pc (
    .bus_clk              (bus_clk),
    .user_w_write_32_open (user_w_write_32_open),
    .imem_data            (imem_data),
    .imem_addr            (imem_addr),
    .instruction          (instruction)
  );

endmodule

// File: tb/tb_stream_issue_ctrl.sv
// Self-checking bench for stream_issue_ctrl: behavioural model plus
// hand-computed checkpoints along a directed stimulus sequence.
module tb_stream_issue_ctrl;

  localparam int unsigned RW   = 40;
  localparam int unsigned AW   = 8;
  localparam int unsigned LAST = 3;
  localparam int unsigned W    = 20;
  localparam int unsigned P    = 6;

  logic          bus_clk = 1'b0;
  logic          open = 1'b0;
  logic          wr_en_in = 1'b1;
  logic          wr_en_out;
  logic          in_fifo_empty = 1'b1;
  logic          in_fifo_rd_en;
  logic          din_v;
  logic          out_fifo_prog_full = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [RW-1:0] imem_data = '0;
  logic [RW-1:0] instruction;
  logic [31:0]   issue_count;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  always #5 bus_clk = ~bus_clk;

  stream_issue_ctrl #(
    .ROM_WIDTH     (RW),
    .ROM_ADDR_BITS (AW),
    .LAST_ADDR     (LAST),
    .WARMUP_CYCLES (W),
    .PERIOD        (P)
  ) dut (
    .bus_clk              (bus_clk),
    .user_w_write_32_open (open),
    .wr_en_in             (wr_en_in),
    .wr_en_out            (wr_en_out),
    .in_fifo_empty        (in_fifo_empty),
    .in_fifo_rd_en        (in_fifo_rd_en),
    .din_v                (din_v),
    .out_fifo_prog_full   (out_fifo_prog_full),
    .imem_addr            (imem_addr),
    .imem_data            (imem_data),
    .instruction          (instruction),
    .issue_count          (issue_count),
    .state                (state)
  );

  function automatic logic [RW-1:0] rom_word(int a);
    if (a >= 0 && a <= int'(LAST)) return RW'(40'hA0 + 40'(a));
    return '0;
  endfunction

  // Schedule ROM stand-in: one-cycle synchronous read.
  always @(posedge bus_clk) imem_data <= rom_word(int'(imem_addr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // rel = edges since reset release; pulses are spaced by edge distance.
  bit              mvalid = 1'b0;
  int              rel = 0;
  int              last_pulse = -1000;
  int              exp_state = 0;
  bit              exp_rd = 1'b0;
  bit              exp_dv = 1'b0;
  int unsigned     exp_cnt = 0;
  bit              m_fire;

  always @(posedge bus_clk) begin
    if (!open) begin
      mvalid     = 1'b1;
      rel        = 0;
      last_pulse = -1000;
      exp_state  = 0;
      exp_rd     = 1'b0;
      exp_dv     = 1'b0;
      exp_cnt    = 0;
    end else begin
      m_fire = (exp_state == 1) && !in_fifo_empty && !out_fifo_prog_full &&
               ((rel + 1 - last_pulse) >= int'(P));
      rel    = rel + 1;
      exp_dv = exp_rd;
      exp_rd = m_fire;
      if (m_fire) begin
        last_pulse = rel;
        exp_cnt    = exp_cnt + 1;
      end
      if (rel < int'(W))       exp_state = 0;
      else if (rel == int'(W)) exp_state = 1;
      else                     exp_state = out_fifo_prog_full ? 2 : 1;
    end
  end

  function automatic logic [RW-1:0] exp_instr(int r);
    if (r == 0) return '0;
    if (r == 1) return rom_word(0);
    return rom_word((r - 2) % int'(LAST + 1));
  endfunction

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge bus_clk) begin
    if (mvalid) begin
      check("state", 64'(state), 64'(exp_state));
      check("rd_en", 64'(in_fifo_rd_en), 64'(exp_rd));
      check("din_v", 64'(din_v), 64'(exp_dv));
      check("issue_count", 64'(issue_count), 64'(exp_cnt));
      check("wr_en_out", 64'(wr_en_out), 64'(wr_en_in && (rel >= int'(W))));
      check("imem_addr", 64'(imem_addr), 64'(rel % int'(LAST + 1)));
      check("instruction", 64'(instruction), 64'(exp_instr(rel)));
    end
  end

  // Advance n falling edges, then step just past them to change inputs.
  task automatic step(input int n);
    repeat (n) @(negedge bus_clk);
    #1;
  endtask

  logic [63:0] empty_vec;
  logic [63:0] pf_vec;
  logic [63:0] wr_vec;

  initial begin
    // Reset with write request held high.
    step(3);
    check("rst_state", 64'(state), 64'd0);
    check("rst_rd", 64'(in_fifo_rd_en), 64'd0);
    check("rst_dv", 64'(din_v), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_instr", 64'(instruction), 64'd0);
    check("rst_cnt", 64'(issue_count), 64'd0);
    check("rst_wr", 64'(wr_en_out), 64'd0);

    // Warm-up: 20 edges before writes pass.
    open = 1'b1;
    step(19);
    check("warm19_state", 64'(state), 64'd0);
    check("warm19_wr", 64'(wr_en_out), 64'd0);
    step(1);
    check("warm20_state", 64'(state), 64'd1);
    check("warm20_wr", 64'(wr_en_out), 64'd1);

    // Continuous supply: pulses at rel 21, 27, ..., 75.
    in_fifo_empty = 1'b0;
    step(55);
    check("pace_cnt10", 64'(issue_count), 64'd10);
    check("pace_rd", 64'(in_fifo_rd_en), 64'd1);
    step(1);
    check("pace_dv", 64'(din_v), 64'd1);
    check("pace_rd_low", 64'(in_fifo_rd_en), 64'd0);

    // Empty gap of 15 cycles, then first pulse one cycle after empty falls.
    in_fifo_empty = 1'b1;
    step(15);
    check("gap_cnt", 64'(issue_count), 64'd10);
    in_fifo_empty = 1'b0;
    step(1);
    check("gap_rd", 64'(in_fifo_rd_en), 64'd1);
    check("gap_cnt11", 64'(issue_count), 64'd11);

    // Back-pressure two cycles after the pulse at rel 92.
    step(1);
    check("bp_dv", 64'(din_v), 64'd1);
    step(1);
    out_fifo_prog_full = 1'b1;
    step(1);
    check("bp_state", 64'(state), 64'd2);
    step(8);
    check("bp_cnt", 64'(issue_count), 64'd11);
    out_fifo_prog_full = 1'b0;
    step(1);
    check("bp_run", 64'(state), 64'd1);
    check("bp_no_rd", 64'(in_fifo_rd_en), 64'd0);
    step(1);
    check("bp_rd", 64'(in_fifo_rd_en), 64'd1);
    check("bp_cnt12", 64'(issue_count), 64'd12);
    check("pc_addr105", 64'(imem_addr), 64'd1);
    check("pc_instr105", 64'(instruction), 64'hA3);

    // Reset in the cycle of a pulse.
    open = 1'b0;
    step(1);
    check("mr_state", 64'(state), 64'd0);
    check("mr_rd", 64'(in_fifo_rd_en), 64'd0);
    check("mr_dv", 64'(din_v), 64'd0);
    check("mr_cnt", 64'(issue_count), 64'd0);
    check("mr_addr", 64'(imem_addr), 64'd0);
    check("mr_instr", 64'(instruction), 64'd0);
    step(2);
    open = 1'b1;
    step(1);
    check("mr_rel1_state", 64'(state), 64'd0);
    check("mr_rel1_dv", 64'(din_v), 64'd0);
    check("mr_rel1_instr", 64'(instruction), 64'hA0);
    step(19);
    check("mr_warm_state", 64'(state), 64'd1);

    // Mixed directed vectors for empty, prog_full and write enable.
    empty_vec = 64'h00F0_000F_0F00_3000;
    pf_vec    = 64'h0F00_0C00_0003_C000;
    wr_vec    = 64'hAAAA_5555_F0F0_0FF0;
    for (int i = 0; i < 64; i++) begin
      in_fifo_empty      = empty_vec[i];
      out_fifo_prog_full = pf_vec[i];
      wr_en_in           = wr_vec[i];
      step(1);
    end
    in_fifo_empty      = 1'b0;
    out_fifo_prog_full = 1'b0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
